fifo_wr_arbiter: RTL and testbench
==================================

// Module: fifo_wr_arbiter
// PURPOSE
//  Round-robin write-port arbiter in front of a single FIFO.
//  Shares one FIFO write port (wr_en/buf_in, throttled by buf_full) between N_REQ producers.
//  Grants one producer at a time for a bounded burst, so no producer can starve the others.
//  Single clock domain; sits on the FIFO write side, same clock as the FIFO write clock.
// PARAMETERS
//  N_REQ  4  number of requesters, >=2
//  DW     8  data width, matches FIFO buf_in width
//  BURST  4  max accepted beats per grant, >=1
// PORTS
//  clk       in   1          single clock, rising edge
//  rst       in   1          asynchronous, active-high reset
//  req       in   N_REQ      req[i]=1: producer i has a valid word on its data slice
//  req_data  in   N_REQ*DW   producer i data in bits [i*DW +: DW]
//  gnt       out  N_REQ      registered one-hot owner; all zeros when idle
//  ack       out  N_REQ      one-hot; ack[i]=1 in the cycle producer i's word is written
//  buf_full  in   1          FIFO full flag
//  wr_en     out  1          FIFO write enable
//  buf_in    out  DW         FIFO write data
//  owner     out  $clog2(N_REQ)  index of current or last owner
//  busy      out  1          1 while in XFER
// BEHAVIOUR
//  Reset: state=IDLE, gnt=0, owner=N_REQ-1 (requester 0 wins first), beat_cnt=0.
//   Outputs at reset: wr_en=0, ack=0, buf_in=0, busy=0.
//  Reset mid-burst: state returns to IDLE asynchronously and wr_en drops immediately.
//   A partially sent burst is abandoned and no pending beat is written.
//  FSM has two states, IDLE and XFER.
//  IDLE, no req bit set: state, owner and gnt are held.
//  IDLE, |req=1: next owner is the first i with req[i]=1, searching from owner+1 and wrapping mod N_REQ.
//   On that edge: owner<=i, gnt<=1<<i, beat_cnt<=0, state<=XFER.
//  XFER, beat condition: beat = req[owner] & ~buf_full.
//   wr_en = beat (combinational from registered state and inputs).
//   buf_in = req_data[owner] when wr_en=1, else 0.
//   ack = wr_en ? gnt : 0.
//  XFER transitions (evaluated each edge):
//   req[owner]=0 -> IDLE; gnt<=0; no write that cycle.
//   beat=1 and beat_cnt==BURST-1 -> IDLE; gnt<=0.
//   beat=1 otherwise -> beat_cnt<=beat_cnt+1; stay in XFER.
//   buf_full=1 with req held -> stall; hold beat_cnt and gnt; no write, no ack.
//  Latency: req asserted in IDLE -> gnt on the next edge -> first write in the cycle after that.
//  Handover: exactly one IDLE bubble cycle between consecutive grants.
//  Fairness: a waiting requester is served within (N_REQ-1)*(BURST+1) write-accepting cycles.
//  Producer handshake: hold req and data stable until ack. Dropping req early ends the grant.
//  Widths: beat_cnt is $clog2(BURST+1) bits. owner rotation is mod N_REQ, also for non-power-of-2 N_REQ.
//  One write per cycle at most, so FIFO overflow is impossible as long as buf_full is exact.
// STRUCTURE
//  Package fifo_arb_pkg holds:
//   state enum {IDLE, XFER}
//   clog2 helper
//   default constants N_REQ_DEF=4, DW_DEF=8, BURST_DEF=4
//  Sub-module rr_pick: combinational rotate-priority selector.
//   Inputs: req[N_REQ], last[$clog2 N].
//   Outputs: found, idx.
//  Top level holds the FSM, beat counter, owner/gnt registers, data mux and ack decode.
// TESTING
//  1. Reset with req=4'b1111 held -> wr_en=0, gnt=0, owner=3.
//     After release: gnt=0001, then 4 writes of req_data[0], then gnt=0010.
//  2. All four requesters continuously active, BURST=4 -> grant order 0,1,2,3,0.
//     Each grant writes 4 words; one idle cycle between grants.
//  3. req[2] only, data 8'hA5; buf_full high for 3 cycles mid-burst.
//     wr_en=0 and ack=0 during the stall, beat_cnt holds.
//     The burst still ends after exactly 4 writes.
//  4. req[1] drops after 2 accepted beats -> IDLE on the next edge.
//     Next grant goes to requester 2 or later in rotation, not back to 1.
//  5. rst asserted mid-burst with beat_cnt=2 -> wr_en=0 immediately, gnt=0, owner=3.
//     The FIFO receives no extra word.
//  6. BURST=1 with req=4'b0101 -> alternating grants 0,2,0,2.
//     One write per grant; check ack one-hot matches gnt on every write.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : fifo_arb_pkg
//  Description : Shared types, defaults and helpers for the FIFO write-port
//                round-robin arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
package fifo_arb_pkg;

    localparam int N_REQ_DEF = 4;
    localparam int DW_DEF    = 8;
    localparam int BURST_DEF = 4;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        XFER = 1'b1
    } arb_state_t;

    // Ceiling log2, returns at least 1 so it is always usable as a width
    function automatic int clog2(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage : fifo_arb_pkg
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational rotate-priority selector. Searches req starting
//                one position after 'last', wrapping mod N_REQ, and returns
//                the first set index.
//  Revision    : 1.0  initial release
// ============================================================================
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int OW    = clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [OW-1:0]    last,
    output logic             found,
    output logic [OW-1:0]    idx
);

    logic [OW-1:0] w_cand;

    // Walk the candidates nearest-first; the first hit wins
    always_comb begin
        found  = 1'b0;
        idx    = last;
        w_cand = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            w_cand = OW'((int'(last) + k) % N_REQ);
            if (!found && req[w_cand]) begin
                found = 1'b1;
                idx   = w_cand;
            end
        end
    end

endmodule : rr_pick
`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_wr_arbiter
//  Description : Round-robin arbiter sharing one FIFO write port between
//                N_REQ producers, granting bounded bursts of up to BURST beats.
//  Revision    : 1.0  initial release
// ============================================================================
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int DW    = DW_DEF,
    parameter int BURST = BURST_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*DW-1:0]     req_data,
    output logic [N_REQ-1:0]        gnt,
    output logic [N_REQ-1:0]        ack,
    input  logic                    buf_full,
    output logic                    wr_en,
    output logic [DW-1:0]           buf_in,
    output logic [clog2(N_REQ)-1:0] owner,
    output logic                    busy
);

    localparam int OW = clog2(N_REQ);
    localparam int CW = clog2(BURST + 1);
    localparam logic [CW-1:0] C_LAST_BEAT = CW'(BURST - 1);
    localparam logic [OW-1:0] C_OWNER_RST = OW'(N_REQ - 1);

    arb_state_t       r_state, w_next_state;
    logic [OW-1:0]    r_owner, w_next_owner;
    logic [N_REQ-1:0] r_gnt,   w_next_gnt;
    logic [CW-1:0]    r_cnt,   w_next_cnt;

    logic             w_found;
    logic [OW-1:0]    w_pick;
    logic             w_beat;

    rr_pick #(
        .N_REQ (N_REQ),
        .OW    (OW)
    ) u_rr_pick (
        .req   (req),
        .last  (r_owner),
        .found (w_found),
        .idx   (w_pick)
    );

    // A beat is accepted when the owner still presents data and the FIFO has room
    assign w_beat = (r_state == XFER) && req[r_owner] && !buf_full;

    assign wr_en  = w_beat;
    assign buf_in = w_beat ? req_data[r_owner*DW +: DW] : '0;
    assign ack    = w_beat ? r_gnt : '0;
    assign gnt    = r_gnt;
    assign owner  = r_owner;
    assign busy   = (r_state == XFER);

    // Next-state: grant on request in IDLE; in XFER end on drop or last beat
    always_comb begin
        w_next_state = r_state;
        w_next_owner = r_owner;
        w_next_gnt   = r_gnt;
        w_next_cnt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_next_state         = XFER;
                    w_next_owner         = w_pick;
                    w_next_gnt           = '0;
                    w_next_gnt[w_pick]   = 1'b1;
                    w_next_cnt           = '0;
                end
            end
            XFER: begin
                if (!req[r_owner]) begin
                    w_next_state = IDLE;
                    w_next_gnt   = '0;
                end else if (w_beat) begin
                    if (r_cnt == C_LAST_BEAT) begin
                        w_next_state = IDLE;
                        w_next_gnt   = '0;
                    end else begin
                        w_next_cnt = r_cnt + CW'(1);
                    end
                end
                // buf_full with req held: everything holds (stall)
            end
            default: begin
                w_next_state = IDLE;
                w_next_gnt   = '0;
            end
        endcase
    end

    // State, owner, grant and beat counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_owner <= C_OWNER_RST;
            r_gnt   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            r_owner <= w_next_owner;
            r_gnt   <= w_next_gnt;
            r_cnt   <= w_next_cnt;
        end
    end

endmodule : fifo_wr_arbiter
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_wr_arbiter
//  Description : Directed self-checking bench for fifo_wr_arbiter (BURST=4
//                instance plus a BURST=1 instance).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fifo_wr_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = '0;
    logic [3:0]  req1 = '0;
    logic [31:0] req_data = '0;
    logic        buf_full = 1'b0;

    logic [3:0]  gnt, ack, gnt1, ack1;
    logic        wr_en, wr_en1, busy, busy1;
    logic [7:0]  buf_in, buf_in1;
    logic [1:0]  owner, owner1;

    int n_checks = 0;
    int n_pass   = 0;
    int n_wr     = 0;
    int w0;

    logic [7:0] dat [4];
    int         seq [5];
    logic [3:0] eg;
    int         g;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(.N_REQ(4), .DW(8), .BURST(4)) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data),
        .gnt(gnt), .ack(ack), .buf_full(buf_full), .wr_en(wr_en),
        .buf_in(buf_in), .owner(owner), .busy(busy)
    );

    fifo_wr_arbiter #(.N_REQ(4), .DW(8), .BURST(1)) dut1 (
        .clk(clk), .rst(rst), .req(req1), .req_data(req_data),
        .gnt(gnt1), .ack(ack1), .buf_full(buf_full), .wr_en(wr_en1),
        .buf_in(buf_in1), .owner(owner1), .busy(busy1)
    );

    // Count words the FIFO actually receives from the main instance
    always @(posedge clk) begin
        if (wr_en) n_wr <= n_wr + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected {gnt, ack, wr_en, buf_in, busy} for a cycle
    function automatic logic [17:0] exp_v(input logic [3:0] eg_i, input logic wr, input logic [7:0] d);
        return {eg_i, (wr ? eg_i : 4'b0000), wr, (wr ? d : 8'h00), |eg_i};
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        dat[0] = 8'h11; dat[1] = 8'h22; dat[2] = 8'h33; dat[3] = 8'h44;
        seq[0] = 0; seq[1] = 1; seq[2] = 2; seq[3] = 3; seq[4] = 0;

        // ---- 1: reset with all requests held
        rst = 1'b1; req = 4'hF; req_data = 32'h44332211;
        step();
        check("rst_out", {gnt, ack, wr_en, buf_in, busy}, 18'h0);
        check("rst_owner", owner, 3);
        step();
        rst = 1'b0;
        step();

        // ---- 2: full round-robin with 4-beat bursts and one idle bubble
        for (int gi = 0; gi < 5; gi++) begin
            g  = seq[gi];
            eg = 4'b0001 << g;
            check($sformatf("t2_owner_g%0d", gi), owner, g);
            for (int b = 0; b < 4; b++) begin
                check($sformatf("t2_g%0d_b%0d", gi, b), {gnt, ack, wr_en, buf_in, busy}, exp_v(eg, 1'b1, dat[g]));
                step();
            end
            check($sformatf("t2_idle%0d", gi), {gnt, ack, wr_en, buf_in, busy}, exp_v(4'b0000, 1'b0, 8'h00));
            step();
        end

        // ---- 3: single requester with a 3-cycle FIFO-full stall
        rst = 1'b1; req = '0; #1;
        step(); rst = 1'b0; step();
        req_data = 32'h44A52211; req = 4'b0100; #1;
        check("t3_pre", {gnt, ack, wr_en, buf_in, busy}, exp_v(4'b0000, 1'b0, 8'h00));
        w0 = n_wr;
        step();
        check("t3_b0", {gnt, ack, wr_en, buf_in, busy}, exp_v(4'b0100, 1'b1, 8'hA5));
        step();
        check("t3_b1", {gnt, ack, wr_en, buf_in, busy}, exp_v(4'b0100, 1'b1, 8'hA5));
        step();
        buf_full = 1'b1; #1;
        for (int s = 0; s < 3; s++) begin
            check($sformatf("t3_stall%0d", s), {gnt, ack, wr_en, buf_in, busy}, exp_v(4'b0100, 1'b0, 8'h00));
            step();
        end
        buf_full = 1'b0; #1;
        check("t3_b2", {gnt, ack, wr_en, buf_in, busy}, exp_v(4'b0100, 1'b1, 8'hA5));
        step();
        check("t3_b3", {gnt, ack, wr_en, buf_in, busy}, exp_v(4'b0100, 1'b1, 8'hA5));
        step();
        req = '0; #1;
        check("t3_end", {gnt, ack, wr_en, buf_in, busy}, exp_v(4'b0000, 1'b0, 8'h00));
        check("t3_nwr", n_wr - w0, 4);

        // ---- 4: owner drops request early; rotation moves past it
        rst = 1'b1; #1;
        step(); rst = 1'b0; step();
        req_data = 32'h4433B111; req = 4'b0110;
        step();
        check("t4_owner1", owner, 1);
        check("t4_b0", {gnt, ack, wr_en, buf_in, busy}, exp_v(4'b0010, 1'b1, 8'hB1));
        step();
        check("t4_b1", {gnt, ack, wr_en, buf_in, busy}, exp_v(4'b0010, 1'b1, 8'hB1));
        step();
        req = 4'b0100; #1;
        check("t4_drop", {gnt, ack, wr_en, buf_in, busy}, exp_v(4'b0010, 1'b0, 8'h00));
        step();
        check("t4_idle", {gnt, ack, wr_en, buf_in, busy}, exp_v(4'b0000, 1'b0, 8'h00));
        req = 4'b0110;
        step();
        check("t4_next_owner", owner, 2);
        check("t4_next", {gnt, ack, wr_en, buf_in, busy}, exp_v(4'b0100, 1'b1, 8'h33));
        req = '0;

        // ---- 5: reset in the middle of a burst (beat_cnt = 2)
        rst = 1'b1; #1;
        step(); rst = 1'b0; step();
        req_data = 32'h44332211; req = 4'b0001; #1;
        w0 = n_wr;
        step(); step(); step();
        check("t5_b2", {gnt, ack, wr_en, buf_in, busy}, exp_v(4'b0001, 1'b1, 8'h11));
        rst = 1'b1; #1;
        check("t5_rst_out", {gnt, ack, wr_en, buf_in, busy}, 18'h0);
        check("t5_rst_owner", owner, 3);
        step();
        check("t5_nwr", n_wr - w0, 2);
        req = '0;

        // ---- 6: BURST=1 instance, requesters 0 and 2 alternate
        req1 = 4'b0101;
        step();
        rst = 1'b0;
        step();
        for (int i = 0; i < 4; i++) begin
            g  = (i % 2 == 0) ? 0 : 2;
            eg = 4'b0001 << g;
            check($sformatf("t6_w%0d", i), {gnt1, ack1, wr_en1, buf_in1, busy1}, exp_v(eg, 1'b1, dat[g]));
            step();
            check($sformatf("t6_idle%0d", i), {gnt1, ack1, wr_en1, buf_in1, busy1}, exp_v(4'b0000, 1'b0, 8'h00));
            step();
        end
        req1 = '0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_fifo_wr_arbiter
`default_nettype wire
